// File: rtl/breakout_pkg.sv
// Shared types and level-pattern generator for the breakout game engine.
package breakout_pkg;

  typedef enum logic [2:0] {
    SERVE    = 3'd0,
    PLAY     = 3'd1,
    LOST     = 3'd2,
    WIN      = 3'd3,
    GAMEOVER = 3'd4
  } game_state_t;

  typedef logic signed [1:0] dir_t;

  localparam dir_t DIR_NEG  = -2'sd1;
  localparam dir_t DIR_ZERO = 2'sd0;
  localparam dir_t DIR_POS  = 2'sd1;

  localparam int MAP_MAX = 256;

  // 8x2 maps use the hand-drawn reference levels; other sizes get a
  // checkerboard whose phase is flipped by the level bit.
  function automatic logic [MAP_MAX-1:0] level_pattern(input logic level,
                                                       input int cols,
                                                       input int block_rows);
    logic [MAP_MAX-1:0] p;
    logic [MAP_MAX-1:0] one;
    p = '0;
    one = '0;
    one[0] = 1'b1;
    if (cols == 8 && block_rows == 2) begin
      p[15:0] = level ? 16'b0101101001000010 : 16'b0100001001011010;
    end else begin
      for (int r = 0; r < block_rows; r++) begin
        for (int c = 0; c < cols; c++) begin
          if ((r * cols + c) < MAP_MAX && ((((r + c) % 2) == 0) != level))
            p = p | (one << (r * cols + c));
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/breakout_score_ctr.sv
// Saturating score counter with clear. Define SCORE_BCD_EN for packed-BCD
// counting (W/4 digits, saturates at all nines); otherwise binary.
module breakout_score_ctr #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] score_o
);

  logic [W-1:0] score_q, score_d;

`ifdef SCORE_BCD_EN
  if (W % 4 != 0) begin : g_bad_width
    $error("breakout_score_ctr: W must be a multiple of 4 for BCD counting");
  end

  localparam logic [W-1:0] ALL9 = {(W/4){4'h9}};

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < W/4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    score_d = (score_q == ALL9) ? score_q : bcd_inc(score_q);
  end
`else
  always_comb begin
    score_d = (&score_q) ? score_q : score_q + W'(1);
  end
`endif

  always_ff @(posedge clk_i) begin
    if (clr_i)      score_q <= '0;
    else if (inc_i) score_q <= score_d;
  end

  assign score_o = score_q;

endmodule

// File: rtl/breakout_core.sv
// Breakout game engine: paddle, ball physics, block map and lives; score
// counting lives in breakout_score_ctr (SCORE_BCD_EN selects BCD).
//   state    | meaning
//   SERVE    | ball rides on the paddle, waiting for launch
//   PLAY     | ball moves one cell per tick
//   LOST     | ball fell out, waiting for a respawn edge
//   WIN      | all blocks cleared, frozen until restart
//   GAMEOVER | no lives left, frozen until restart
module breakout_core
  import breakout_pkg::*;
#(
  parameter int COLS       = 8,
  parameter int ROWS       = 8,
  parameter int BLOCK_ROWS = 2,
  parameter int PADDLE_W   = 3,
  parameter int LIVES      = 4,
  parameter int SCORE_W    = 8
) (
  input  logic                           CLK,
  input  logic                           restart,
  input  logic                           tick,
  input  logic                           btn_left,
  input  logic                           btn_right,
  input  logic                           launch,
  input  logic                           respawn,
  input  logic                           pause,
  input  logic                           level_sel,
  output logic [$clog2(COLS)-1:0]        paddle_x,
  output logic [$clog2(COLS)-1:0]        ball_x,
  output logic [$clog2(ROWS)-1:0]        ball_y,
  output logic [BLOCK_ROWS*COLS-1:0]     block_map,
  output logic [$clog2(LIVES+1)-1:0]     lives,
  output logic [SCORE_W-1:0]             score,
  output logic                           hit,
  output logic [2:0]                     state
);

  localparam int XW       = $clog2(COLS);
  localparam int YW       = $clog2(ROWS);
  localparam int LW       = $clog2(LIVES+1);
  localparam int NB       = BLOCK_ROWS * COLS;
  localparam int PAD_MAX  = COLS - PADDLE_W;
  localparam int PAD_INIT = (COLS - PADDLE_W) / 2;
  localparam int HALF     = PADDLE_W / 2;

  localparam logic [MAP_MAX-1:0] PAT0_FULL = level_pattern(1'b0, COLS, BLOCK_ROWS);
  localparam logic [MAP_MAX-1:0] PAT1_FULL = level_pattern(1'b1, COLS, BLOCK_ROWS);
  localparam logic [NB-1:0]      PAT0      = PAT0_FULL[NB-1:0];
  localparam logic [NB-1:0]      PAT1      = PAT1_FULL[NB-1:0];

  game_state_t   state_q, state_d;
  logic [XW-1:0] paddle_q, paddle_d, bx_q, bx_d;
  logic [YW-1:0] by_q, by_d;
  dir_t          dx_q, dx_d, dy_q, dy_d;
  logic [NB-1:0] map_q, map_d, cell_mask;
  logic [LW-1:0] lives_q, lives_d;
  logic          hit_q, hit_d, score_inc;
  logic          left_q, right_q, resp_q;
  logic          left_rise, right_rise, resp_rise, can_move, blk_hit, on_paddle;
  int            xq, yq, pq, dxw, tx, ty, col, pdx;

  always_comb begin
    state_d   = state_q;
    paddle_d  = paddle_q;
    bx_d      = bx_q;
    by_d      = by_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    map_d     = map_q;
    lives_d   = lives_q;
    hit_d     = 1'b0;
    score_inc = 1'b0;

    left_rise  = btn_left & ~left_q;
    right_rise = btn_right & ~right_q;
    resp_rise  = respawn & ~resp_q;

    xq  = int'(bx_q);
    yq  = int'(by_q);
    pq  = int'(paddle_q);
    dxw = int'(dx_q);
    if (xq + dxw < 0 || xq + dxw > COLS - 1) dxw = -dxw;
    tx = xq + dxw;
    ty = yq + int'(dy_q);

    cell_mask = '0;
    if (ty >= ROWS - BLOCK_ROWS && ty <= ROWS - 1)
      cell_mask = NB'(1) << ((ROWS - 1 - ty) * COLS + tx);
    blk_hit = |(map_q & cell_mask);

    // Paddle edge columns deflect sideways; bounce off a wall if that points out.
    col       = xq - pq;
    on_paddle = (yq == 1) && (dy_q == DIR_NEG) && (col >= 0) && (col < PADDLE_W);
    pdx       = (col == 0) ? -1 : ((col == PADDLE_W - 1) ? 1 : 0);
    if (xq + pdx < 0 || xq + pdx > COLS - 1) pdx = -pdx;

    can_move = !pause && (state_q == SERVE || state_q == PLAY);
    if (can_move) begin
      if (left_rise && !right_rise && pq > 0)
        paddle_d = paddle_q - XW'(1);
      else if (right_rise && !left_rise && pq < PAD_MAX)
        paddle_d = paddle_q + XW'(1);
    end

    case (state_q)
      SERVE: begin
        bx_d = paddle_d + XW'(HALF);
        by_d = YW'(1);
        if (launch && !pause) begin
          state_d = PLAY;
          dx_d    = DIR_ZERO;
          dy_d    = DIR_POS;
        end
      end
      PLAY: begin
        if (tick && !pause) begin
          dx_d = dir_t'(dxw);
          if (yq == ROWS - 1 && dy_q == DIR_POS) begin
            dy_d = DIR_NEG;
          end else if (blk_hit) begin
            map_d     = map_q & ~cell_mask;
            hit_d     = 1'b1;
            score_inc = 1'b1;
            dy_d      = -dy_q;
          end else if (on_paddle) begin
            dy_d = DIR_POS;
            dx_d = dir_t'(pdx);
          end else begin
            bx_d = XW'(tx);
            by_d = YW'(ty);
            if (ty == 0) begin
              state_d = LOST;
              if (lives_q != '0) lives_d = lives_q - LW'(1);
            end
          end
          if (map_d == '0) state_d = WIN;
        end
      end
      LOST: begin
        if (resp_rise) begin
          if (lives_q != '0) begin
            state_d = SERVE;
            bx_d    = paddle_q + XW'(HALF);
            by_d    = YW'(1);
            dx_d    = DIR_ZERO;
            dy_d    = DIR_POS;
          end else begin
            state_d = GAMEOVER;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (restart) begin
      state_q  <= SERVE;
      paddle_q <= XW'(PAD_INIT);
      bx_q     <= XW'(PAD_INIT + HALF);
      by_q     <= YW'(1);
      dx_q     <= DIR_ZERO;
      dy_q     <= DIR_POS;
      map_q    <= level_sel ? PAT1 : PAT0;
      lives_q  <= LW'(LIVES);
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddle_q <= paddle_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      map_q    <= map_d;
      lives_q  <= lives_d;
      hit_q    <= hit_d;
    end
    // Edge detectors follow the inputs in both branches so restart never fakes an edge.
    left_q  <= btn_left;
    right_q <= btn_right;
    resp_q  <= respawn;
  end

  breakout_score_ctr #(.W(SCORE_W)) u_score (
    .clk_i   (CLK),
    .clr_i   (restart),
    .inc_i   (score_inc),
    .score_o (score)
  );

  assign paddle_x  = paddle_q;
  assign ball_x    = bx_q;
  assign ball_y    = by_q;
  assign block_map = map_q;
  assign lives     = lives_q;
  assign hit       = hit_q;
  assign state     = state_q;

endmodule

// File: tb/tb_breakout_core.sv
// Directed bench: default 8x8 engine, a small 4x4 engine for the win path,
// and the score counter on its own for saturation.
module tb_breakout_core;
  import breakout_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic rst, tick, bl, br, launch, resp, pause, lvl;
  logic [2:0]  pad, bx, by, lives, st;
  logic [15:0] map;
  logic [7:0]  score;
  logic        hit;

  logic b_rst, b_tick, b_bl, b_br, b_launch, b_resp, b_pause, b_lvl;
  logic [1:0] b_pad, b_bx, b_by, b_lives;
  logic [3:0] b_map;
  logic [7:0] b_score;
  logic       b_hit;
  logic [2:0] b_st;

  logic       s_clr, s_inc;
  logic [7:0] s_val;

  breakout_core dut (
    .CLK(CLK), .restart(rst), .tick(tick), .btn_left(bl), .btn_right(br),
    .launch(launch), .respawn(resp), .pause(pause), .level_sel(lvl),
    .paddle_x(pad), .ball_x(bx), .ball_y(by), .block_map(map), .lives(lives),
    .score(score), .hit(hit), .state(st)
  );

  breakout_core #(.COLS(4), .ROWS(4), .BLOCK_ROWS(1), .PADDLE_W(2), .LIVES(2), .SCORE_W(8)) dut_b (
    .CLK(CLK), .restart(b_rst), .tick(b_tick), .btn_left(b_bl), .btn_right(b_br),
    .launch(b_launch), .respawn(b_resp), .pause(b_pause), .level_sel(b_lvl),
    .paddle_x(b_pad), .ball_x(b_bx), .ball_y(b_by), .block_map(b_map), .lives(b_lives),
    .score(b_score), .hit(b_hit), .state(b_st)
  );

  breakout_score_ctr #(.W(8)) u_ctr (
    .clk_i(CLK), .clr_i(s_clr), .inc_i(s_inc), .score_o(s_val)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  task automatic b_ticks(input int n);
    b_tick = 1'b1;
    repeat (n) step();
    b_tick = 1'b0;
  endtask

  task automatic edge_left();
    bl = 1'b1; step(); bl = 1'b0; step();
  endtask

  task automatic edge_right();
    br = 1'b1; step(); br = 1'b0; step();
  endtask

  task automatic edge_resp();
    resp = 1'b1; step(); resp = 1'b0; step();
  endtask

  // Serve from column 3 (no blocks left there), move the paddle away and let the ball drop.
  task automatic lose_life(input int exp_lives);
    edge_resp();
    check("respawn_state", st, 0);
    check("respawn_ball_x", bx, 1);
    edge_right();
    edge_right();
    check("serve_track_x", bx, 3);
    launch = 1'b1; step(); launch = 1'b0;
    edge_left();
    edge_left();
    ticks(14);
    check("lost_state", st, 2);
    check("lost_lives", lives, exp_lives);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    {rst, tick, bl, br, launch, resp, pause, lvl} = '0;
    {b_rst, b_tick, b_bl, b_br, b_launch, b_resp, b_pause, b_lvl} = '0;
    s_clr = 1'b1; s_inc = 1'b0;
    rst = 1'b1; b_rst = 1'b1;
    step(); step();
    rst = 1'b0; b_rst = 1'b0; s_clr = 1'b0;

    // Reset values, level 0
    check("rst_paddle", pad, 2);
    check("rst_ball_x", bx, 3);
    check("rst_ball_y", by, 1);
    check("rst_map", map, 16'b0100001001011010);
    check("rst_lives", lives, 4);
    check("rst_state", st, 0);
    check("rst_score", score, 0);
    check("rst_hit", hit, 0);

    pause = 1'b1; launch = 1'b1; step();
    check("pause_blocks_launch", st, 0);
    pause = 1'b0; launch = 1'b0; step();

    edge_left(); edge_left(); edge_left();
    check("left_clamp", pad, 0);
    check("serve_track", bx, 1);
    bl = 1'b1; br = 1'b1; step(); bl = 1'b0; br = 1'b0; step();
    check("both_edges_no_move", pad, 0);
    repeat (7) edge_right();
    check("right_clamp", pad, 5);
    check("right_clamp_ball", bx, 6);

    // Level 1: launch straight up into the block at (3,6)
    lvl = 1'b1; rst = 1'b1; step(); rst = 1'b0; lvl = 1'b0; step();
    check("lvl1_map", map, 16'b0101101001000010);
    launch = 1'b1; tick = 1'b1; step(); launch = 1'b0; tick = 1'b0;
    check("launch_state", st, 1);
    check("launch_no_step", by, 1);
    ticks(4);
    check("rise_y", by, 5);
    ticks(1);
    check("block_hit_pulse", hit, 1);
    check("block_score", score, 1);
    check("block_cleared", map, 16'h5242);
    check("block_ball_stays", by, 5);
    step();
    check("hit_one_cycle", hit, 0);
    edge_left();
    check("paddle_move_play", pad, 1);
    ticks(4);
    check("descend_y", by, 1);
    ticks(1);
    check("paddle_bounce_stays", by, 1);
    ticks(1);
    check("bounce_right_x", bx, 4);
    check("bounce_right_y", by, 2);

    // Level 0: one block hit, then drop past the paddle
    rst = 1'b1; step(); rst = 1'b0; step();
    launch = 1'b1; step(); launch = 1'b0;
    edge_left(); edge_left();
    ticks(12);
    check("first_lost_state", st, 2);
    check("first_lost_lives", lives, 3);
    check("first_lost_y", by, 0);
    check("first_lost_score", score, 1);
    lose_life(2);
    lose_life(1);
    lose_life(0);
    edge_resp();
    check("gameover_state", st, 4);
    edge_right();
    launch = 1'b1; step(); launch = 1'b0; step();
    check("gameover_frozen_state", st, 4);
    check("gameover_frozen_paddle", pad, 0);
    check("gameover_frozen_ball", by, 0);
    rst = 1'b1; step(); rst = 1'b0; step();
    check("restart_state", st, 0);
    check("restart_lives", lives, 4);
    check("restart_score", score, 0);

    // Pause freezes physics and paddle
    launch = 1'b1; step(); launch = 1'b0;
    ticks(3);
    check("pre_pause_y", by, 4);
    pause = 1'b1;
    ticks(10);
    edge_right();
    check("pause_ball_y", by, 4);
    check("pause_ball_x", bx, 3);
    check("pause_paddle", pad, 2);
    pause = 1'b0; step();
    ticks(1);
    check("unpause_step", by, 5);

    // Small 4x4 engine: clear both blocks and win
    b_rst = 1'b1; step(); b_rst = 1'b0; step();
    check("b_map", b_map, 4'b0101);
    check("b_paddle", b_pad, 1);
    check("b_ball_x", b_bx, 2);
    check("b_lives", b_lives, 2);
    b_launch = 1'b1; step(); b_launch = 1'b0;
    b_ticks(2);
    check("b_hit1", b_hit, 1);
    check("b_score1", b_score, 1);
    check("b_map1", b_map, 4'b0001);
    b_ticks(1);
    b_br = 1'b1; step(); b_br = 1'b0; step();
    check("b_paddle_right", b_pad, 2);
    b_ticks(2);
    check("b_left_deflect_x", b_bx, 1);
    check("b_left_deflect_y", b_by, 2);
    b_ticks(1);
    check("b_win_state", b_st, 3);
    check("b_win_map", b_map, 0);
    check("b_win_score", b_score, 2);
    b_ticks(5);
    b_bl = 1'b1; step(); b_bl = 1'b0; step();
    check("b_win_frozen_state", b_st, 3);
    check("b_win_frozen_x", b_bx, 1);
    check("b_win_frozen_y", b_by, 2);
    check("b_win_frozen_paddle", b_pad, 2);

    // Binary score saturation
    s_clr = 1'b1; step(); s_clr = 1'b0;
    s_inc = 1'b1; step(); s_inc = 1'b0;
    check("ctr_one", s_val, 1);
    s_inc = 1'b1; repeat (253) step(); s_inc = 1'b0;
    check("ctr_254", s_val, 254);
    s_inc = 1'b1; repeat (3) step(); s_inc = 1'b0;
    check("ctr_saturate", s_val, 8'hff);
    s_clr = 1'b1; step(); s_clr = 1'b0;
    check("ctr_clear", s_val, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
